// File: rtl/full_subtractor_pkg.sv
// Shared definitions for the full_subtractor block: default width, result record, borrow equation.
package full_subtractor_pkg;

  localparam int FULL_SUBTRACTOR_DEFAULT_WIDTH = 1;
  localparam int FULL_SUBTRACTOR_MAX_WIDTH     = 64;

  // Result record sized for the widest legal operand; narrower users zero-extend.
  typedef struct packed {
    logic [FULL_SUBTRACTOR_MAX_WIDTH-1:0] difference;
    logic                                 borrow;
  } full_subtractor_result_t;

  function automatic logic borrow_out(input logic a, input logic b, input logic bin);
    return (~a & b) | (~a & bin) | (b & bin);
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit combinational full subtractor; chained through Bin/Borrow to form a ripple subtractor.
module full_subtractor_cell
  import full_subtractor_pkg::*;
(
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Difference,
  output logic Borrow
);

  assign Difference = A ^ B ^ Bin;
  assign Borrow     = borrow_out(A, B, Bin);

endmodule

// File: rtl/full_subtractor.sv
// Registered ripple-borrow subtractor: (A - B - Bin) mod 2^WIDTH with borrow-out, 1-cycle latency.
// Define FULL_SUBTRACTOR_OVERFLOW_EN to add a registered signed-overflow output.
module full_subtractor
  import full_subtractor_pkg::*;
#(
  parameter int WIDTH = FULL_SUBTRACTOR_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Difference,
  output logic             Borrow,
`ifdef FULL_SUBTRACTOR_OVERFLOW_EN
  output logic             out_valid,
  output logic             Overflow
`else
  output logic             out_valid
`endif
);

  logic [WIDTH:0]   br_p0;
  logic [WIDTH-1:0] diff_p0;

  assign br_p0[0] = Bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_subtractor_cell u_cell (
      .A          (A[i]),
      .B          (B[i]),
      .Bin        (br_p0[i]),
      .Difference (diff_p0[i]),
      .Borrow     (br_p0[i+1])
    );
  end

  // p0 -> p1: results only advance on accepted inputs; valid tracks every edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Difference <= '0;
      Borrow     <= 1'b0;
      out_valid  <= 1'b0;
`ifdef FULL_SUBTRACTOR_OVERFLOW_EN
      Overflow   <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Difference <= diff_p0;
        Borrow     <= br_p0[WIDTH];
`ifdef FULL_SUBTRACTOR_OVERFLOW_EN
        Overflow   <= br_p0[WIDTH] ^ br_p0[WIDTH-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_full_subtractor.sv
// Directed bench for full_subtractor at WIDTH=1 and WIDTH=8, hand-computed expectations.
module tb_full_subtractor;
  import full_subtractor_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  logic       v1, a1, b1, bin1;
  logic       d1, bo1, ov1;
  logic       v8, bin8;
  logic [7:0] a8, b8, d8;
  logic       bo8, ov8;
`ifdef FULL_SUBTRACTOR_OVERFLOW_EN
  logic       of1, of8;
`endif

  int tests = 0;
  int fails = 0;

  full_subtractor_result_t exp_r;
  logic [1:0] exp1 [8];

  always #5 clk = ~clk;

  full_subtractor #(.WIDTH(1)) u_w1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (v1),
    .A          (a1),
    .B          (b1),
    .Bin        (bin1),
    .Difference (d1),
    .Borrow     (bo1),
`ifdef FULL_SUBTRACTOR_OVERFLOW_EN
    .out_valid  (ov1),
    .Overflow   (of1)
`else
    .out_valid  (ov1)
`endif
  );

  full_subtractor #(.WIDTH(8)) u_w8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (v8),
    .A          (a8),
    .B          (b8),
    .Bin        (bin8),
    .Difference (d8),
    .Borrow     (bo8),
`ifdef FULL_SUBTRACTOR_OVERFLOW_EN
    .out_valid  (ov8),
    .Overflow   (of8)
`else
    .out_valid  (ov8)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_w8(input string tag, input logic [7:0] d, input logic bo, input logic ov);
    check({tag, ".diff"},   64'(d8),  64'(d));
    check({tag, ".borrow"}, 64'(bo8), 64'(bo));
    check({tag, ".valid"},  64'(ov8), 64'(ov));
  endtask

  initial begin
    exp1 = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    rst_n = 1'b0;
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
    v8 = 1'b1; a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0;

    // Reset state, with a valid input present that must be discarded
    #12;
    check("rst.w1.diff",   64'(d1),  64'd0);
    check("rst.w1.borrow", 64'(bo1), 64'd0);
    check("rst.w1.valid",  64'(ov1), 64'd0);
    check_w8("rst.w8", 8'h00, 1'b0, 1'b0);
`ifdef FULL_SUBTRACTOR_OVERFLOW_EN
    check("rst.w8.ovf", 64'(of8), 64'd0);
`endif
    v8 = 1'b0;

    // WIDTH=1 truth table, one vector per cycle
    @(negedge clk);
    rst_n = 1'b1;
    v1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      {a1, b1, bin1} = 3'(i);
      @(posedge clk); #1;
      check($sformatf("tt%0d.diff", i),   64'(d1),  64'(exp1[i][1]));
      check($sformatf("tt%0d.borrow", i), 64'(bo1), 64'(exp1[i][0]));
      check($sformatf("tt%0d.valid", i),  64'(ov1), 64'd1);
    end
    v1 = 1'b0; {a1, b1, bin1} = 3'b000;
    @(posedge clk); #1;
    check("w1.hold.diff",   64'(d1),  64'd1);
    check("w1.hold.borrow", 64'(bo1), 64'd1);
    check("w1.hold.valid",  64'(ov1), 64'd0);

    // WIDTH=8 wrap and A==B with borrow-in
    v8 = 1'b1; a8 = 8'h00; b8 = 8'h01; bin8 = 1'b0;
    @(posedge clk); #1;
    check_w8("w8.0m1", 8'hFF, 1'b1, 1'b1);
    a8 = 8'h05; b8 = 8'h05; bin8 = 1'b1;
    @(posedge clk); #1;
    exp_r = '{difference: 64'hFF, borrow: 1'b1};
    check_w8("w8.5m5m1", exp_r.difference[7:0], exp_r.borrow, 1'b1);

    // Signed overflow boundary and its non-overflow neighbour
    a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0;
    @(posedge clk); #1;
    check_w8("w8.80m1", 8'h7F, 1'b0, 1'b1);
`ifdef FULL_SUBTRACTOR_OVERFLOW_EN
    check("w8.80m1.ovf", 64'(of8), 64'd1);
`endif
    a8 = 8'h10; b8 = 8'h01;
    @(posedge clk); #1;
    check_w8("w8.10m1", 8'h0F, 1'b0, 1'b1);
`ifdef FULL_SUBTRACTOR_OVERFLOW_EN
    check("w8.10m1.ovf", 64'(of8), 64'd0);
`endif
    a8 = 8'h3C; b8 = 8'hA5; bin8 = 1'b1;
    @(posedge clk); #1;
    check_w8("w8.3CmA5m1", 8'h96, 1'b1, 1'b1);

    // Hold: result stays while in_valid is low
    a8 = 8'h03; b8 = 8'h01; bin8 = 1'b0;
    @(posedge clk); #1;
    check_w8("w8.3m1", 8'h02, 1'b0, 1'b1);
    v8 = 1'b0; a8 = 8'h00; b8 = 8'h01;
    @(posedge clk); #1;
    check_w8("w8.hold", 8'h02, 1'b0, 1'b0);

    // Mid-stream reset between edges, then first accepted input one cycle after release
    v8 = 1'b1; a8 = 8'h09; b8 = 8'h02; bin8 = 1'b0;
    @(posedge clk); #1;
    check_w8("w8.9m2", 8'h07, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_w8("mid.rst", 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_w8("mid.rst.edge", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    a8 = 8'h01; b8 = 8'h02; bin8 = 1'b0;
    #1;
    check_w8("post.rst.idle", 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_w8("post.rst.first", 8'hFF, 1'b1, 1'b1);
    v8 = 1'b0;
    @(posedge clk); #1;
    check("post.rst.drop", 64'(ov8), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/full_subtractor.md
FULL_SUBTRACTOR -- requirements
Module: full_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 1: operand width in bits, legal range 1..64.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid, input, 1: A/B/Bin sampled this cycle when high.
REQ-005 SHALL have port A, input, WIDTH: minuend.
REQ-006 SHALL have port B, input, WIDTH: subtrahend.
REQ-007 SHALL have port Bin, input, 1: borrow-in.
REQ-008 SHALL have port Difference, output, WIDTH: registered (A - B - Bin) mod 2^WIDTH.
REQ-009 SHALL have port Borrow, output, 1: registered borrow-out.
REQ-010 SHALL have port out_valid, output, 1: Difference/Borrow updated from an accepted input.

Function
REQ-011 SHALL compute per bit i: D[i] = A[i] ^ B[i] ^ br[i]; br[i+1] = (~A[i] & B[i]) | (~A[i] & br[i]) | (B[i] & br[i]); br[0] = Bin.
REQ-012 SHALL set Borrow = br[WIDTH], equal to 1 exactly when unsigned A < B + Bin.
REQ-013 SHALL register Difference and Borrow on the rising clk edge where in_valid = 1; latency exactly 1 cycle.
REQ-014 SHALL hold Difference and Borrow unchanged on edges where in_valid = 0.
REQ-015 SHALL register out_valid <= in_valid every edge, with no backpressure.
REQ-016 SHALL treat Bin = 1 with A = B as Difference = all ones and Borrow = 1.
REQ-017 SHALL wrap modulo 2^WIDTH with no saturation.
REQ-018 SHALL accept a new input every cycle at full throughput.

Reset
REQ-019 SHALL clear Difference, Borrow, out_valid (and Overflow when present) to 0 immediately while rst_n = 0, independent of clk.
REQ-020 SHALL discard any input presented during reset, and SHALL accept the first input at the first rising edge with rst_n = 1.
REQ-021 SHALL apply reset mid-stream so that no stale result appears with out_valid = 1 after release.

Configuration
REQ-022 SHALL, when macro FULL_SUBTRACTOR_OVERFLOW_EN is defined, add output Overflow, 1 bit, registered with the same timing as Borrow, equal to br[WIDTH] ^ br[WIDTH-1] (signed two's-complement overflow).
REQ-023 SHALL, when FULL_SUBTRACTOR_OVERFLOW_EN is undefined, omit the Overflow port and its logic entirely, leaving all other behaviour identical.

Structure
REQ-024 SHALL place constant FULL_SUBTRACTOR_DEFAULT_WIDTH (1) and a result struct/typedef {Difference, Borrow} in shared package full_subtractor_pkg.
REQ-025 SHALL implement one combinational sub-module full_subtractor_cell (ports A, B, Bin, Difference, Borrow; 1 bit each), instantiated WIDTH times as a ripple chain.
REQ-026 SHALL contain no latches, and every register SHALL be reset.

Verification
REQ-027 SHALL cover WIDTH=1 with all 8 (A, B, Bin) vectors, one per cycle, in order 000..111 -> (Difference, Borrow) = 00, 11, 11, 01, 10, 00, 00, 11, each one cycle later with out_valid = 1.
REQ-028 SHALL cover WIDTH=8, A=0x00, B=0x01, Bin=0 -> Difference=0xFF, Borrow=1; A=0x05, B=0x05, Bin=1 -> 0xFF, Borrow=1.
REQ-029 SHALL cover WIDTH=8 with FULL_SUBTRACTOR_OVERFLOW_EN, A=0x80, B=0x01, Bin=0 -> Difference=0x7F, Borrow=0, Overflow=1; A=0x10, B=0x01 -> 0x0F, Overflow=0.
REQ-030 SHALL cover hold: in_valid=1 with A=3, B=1, then in_valid=0 with A=0, B=1 -> Difference stays 2 and out_valid drops to 0.
REQ-031 SHALL cover reset asserted mid-stream between clock edges -> all outputs 0 within the same timestep; after release, first valid input result appears 1 cycle later.
